// File: rtl/ahb_apb_bridge_mslv.sv
// AHB-to-APB bridge for several APB slaves. The slave is chosen by an index
// field in haddr. The bridge inserts AHB wait states until the selected slave
// asserts pready. A slave error, a decode miss or a pready timeout is returned
// as a two-cycle AHB ERROR response.
module ahb_apb_bridge_mslv #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_SLAVES = 4,
  parameter int SEL_LSB    = 12,
  parameter int TIMEOUT    = 255
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         hsel,
  input  logic [ADDR_W-1:0]            haddr,
  input  logic [1:0]                   htrans,
  input  logic                         hwrite,
  input  logic [DATA_W-1:0]            hwdata,
  input  logic                         hready,
  output logic                         hreadyout,
  output logic [DATA_W-1:0]            hrdata,
  output logic                         hresp,
  output logic [ADDR_W-1:0]            paddr,
  output logic [NUM_SLAVES-1:0]        psel,
  output logic                         penable,
  output logic                         pwrite,
  output logic [DATA_W-1:0]            pwdata,
  input  logic [NUM_SLAVES*DATA_W-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]        pready,
  input  logic [NUM_SLAVES-1:0]        pslverr
);

  // The index register keeps at least one bit so that a single-slave build still has a legal width.
  localparam int SEL_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int SEL_W1 = SEL_W + 1;
  localparam int TO_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TO_W1  = TO_W + 1;
  localparam logic [TO_W:0]  TO_LIM = TO_W1'(TIMEOUT);
  localparam logic [SEL_W:0] NS_LIM = SEL_W1'(NUM_SLAVES);
  localparam logic           TO_EN  = (TIMEOUT != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WDATA  = 3'd1,
    S_SETUP  = 3'd2,
    S_ACCESS = 3'd3,
    S_DONE   = 3'd4,
    S_ERR1   = 3'd5,
    S_ERR2   = 3'd6
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [SEL_W-1:0]        r_idx;
  logic [SEL_W-1:0]        w_idx_addr;
  logic [SEL_W-1:0]        w_idx_nxt;
  logic                    w_can_accept;
  logic                    w_accept;
  logic                    w_miss;
  logic                    w_pready_sel;
  logic                    w_pslverr_sel;
  logic [DATA_W-1:0]       w_prdata_sel;
  logic [TO_W-1:0]         r_cnt;
  logic                    w_to_hit;
  logic [NUM_SLAVES-1:0]   w_psel_nxt;
  logic                    w_sel_phase_nxt;
  logic                    w_htrans_unused;

  logic                    r_hreadyout;
  logic [DATA_W-1:0]       r_hrdata;
  logic                    r_hresp;
  logic [ADDR_W-1:0]       r_paddr;
  logic [NUM_SLAVES-1:0]   r_psel;
  logic                    r_penable;
  logic                    r_pwrite;
  logic [DATA_W-1:0]       r_pwdata;

  // Slave index field. A single-slave build has no field and always selects slave 0.
  generate
    if (NUM_SLAVES > 1) begin : g_idx
      assign w_idx_addr = haddr[SEL_LSB +: SEL_W];
    end else begin : g_idx_one
      assign w_idx_addr = '0;
    end
  endgenerate

  // Only htrans[1] separates NONSEQ/SEQ from IDLE/BUSY.
  assign w_htrans_unused = htrans[0];

  // A new transfer is taken only in a state that drives hreadyout high.
  assign w_can_accept = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR2);
  assign w_accept     = w_can_accept & hsel & hready & htrans[1];
  assign w_miss       = ({1'b0, w_idx_addr} >= NS_LIM);
  assign w_idx_nxt    = w_accept ? w_idx_addr : r_idx;

  // The timeout fires in the ACCESS cycle whose increment makes the counter reach TIMEOUT.
  assign w_to_hit = TO_EN && (({1'b0, r_cnt} + TO_W1'(1)) == TO_LIM);

  // Select only the addressed slave's response; all other slaves are ignored.
  always_comb begin
    w_pready_sel  = 1'b0;
    w_pslverr_sel = 1'b0;
    w_prdata_sel  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      w_pready_sel  = w_pready_sel  | ((r_idx == SEL_W'(i)) & pready[i]);
      w_pslverr_sel = w_pslverr_sel | ((r_idx == SEL_W'(i)) & pslverr[i]);
      w_prdata_sel  = w_prdata_sel  |
                      ({DATA_W{r_idx == SEL_W'(i)}} & prdata[i*DATA_W +: DATA_W]);
    end
  end

  // Next-state logic of the bridge FSM.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR2: begin
        if (w_accept) begin
          if (w_miss) begin
            w_state_nxt = S_ERR1;
          end else if (hwrite) begin
            w_state_nxt = S_WDATA;
          end else begin
            w_state_nxt = S_SETUP;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WDATA:  w_state_nxt = S_SETUP;
      S_SETUP:  w_state_nxt = S_ACCESS;
      S_ACCESS: begin
        if (w_pready_sel) begin
          w_state_nxt = w_pslverr_sel ? S_ERR1 : S_DONE;
        end else if (w_to_hit) begin
          w_state_nxt = S_ERR1;
        end else begin
          w_state_nxt = S_ACCESS;
        end
      end
      S_ERR1:   w_state_nxt = S_ERR2;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Build the one-hot select for the next state. The result is zero outside SETUP and ACCESS.
  always_comb begin
    w_sel_phase_nxt = (w_state_nxt == S_SETUP) || (w_state_nxt == S_ACCESS);
    w_psel_nxt      = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      w_psel_nxt[i] = w_sel_phase_nxt & (w_idx_nxt == SEL_W'(i));
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ACCESS cycle counter. It clears when a transfer enters SETUP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_state_nxt == S_SETUP) begin
      r_cnt <= '0;
    end else if (r_state == S_ACCESS) begin
      r_cnt <= r_cnt + TO_W'(1);
    end
  end

  // Address-phase capture, write data capture and read data return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_idx    <= '0;
      r_pwdata <= '0;
      r_hrdata <= '0;
    end else begin
      if (w_accept) begin
        r_paddr  <= haddr;
        r_pwrite <= hwrite;
        r_idx    <= w_idx_addr;
      end
      if (r_state == S_WDATA) begin
        r_pwdata <= hwdata;
      end
      if ((r_state == S_ACCESS) && w_pready_sel && !w_pslverr_sel && !r_pwrite) begin
        r_hrdata <= w_prdata_sel;
      end
    end
  end

  // Handshake outputs, registered from the next state so that they line up with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_psel      <= '0;
      r_penable   <= 1'b0;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
    end else begin
      r_psel      <= w_psel_nxt;
      r_penable   <= (w_state_nxt == S_ACCESS);
      r_hreadyout <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_DONE) ||
                     (w_state_nxt == S_ERR2);
      r_hresp     <= (w_state_nxt == S_ERR1) || (w_state_nxt == S_ERR2);
    end
  end

  assign hreadyout = r_hreadyout;
  assign hrdata    = r_hrdata;
  assign hresp     = r_hresp;
  assign paddr     = r_paddr;
  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign pwdata    = r_pwdata;

endmodule
